// File: rtl/neo_frame_arbiter_if.sv
// Bundles the producer-side and driver-side signals of the NeoPixel frame arbiter.
// Producer fields are flat vectors: producer i sits at [3i+:3], [2i+:2], [8i+:8].
interface neo_frame_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_load_color;
  logic [NUM_REQ-1:0]   req_send_it;
  logic [3*NUM_REQ-1:0] req_pixel_index;
  logic [2*NUM_REQ-1:0] req_color_index;
  logic [8*NUM_REQ-1:0] req_color_level;
  logic                 ready_to_load;
  logic                 ready_to_send;

  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   gnt_ready_to_load;
  logic [NUM_REQ-1:0]   gnt_ready_to_send;
  logic                 load_color;
  logic                 send_it;
  logic [2:0]           pixel_index;
  logic [1:0]           color_index;
  logic [7:0]           color_level;
  logic [IW-1:0]        owner_id;
  logic                 busy;
  logic                 timeout_err;

  // Producers and driver.
  modport master (
    output req, req_load_color, req_send_it, req_pixel_index, req_color_index,
           req_color_level, ready_to_load, ready_to_send,
    input  gnt, gnt_ready_to_load, gnt_ready_to_send, load_color, send_it, pixel_index,
           color_index, color_level, owner_id, busy, timeout_err
  );

  // Arbiter.
  modport slave (
    input  req, req_load_color, req_send_it, req_pixel_index, req_color_index,
           req_color_level, ready_to_load, ready_to_send,
    output gnt, gnt_ready_to_load, gnt_ready_to_send, load_color, send_it, pixel_index,
           color_index, color_level, owner_id, busy, timeout_err
  );
endinterface

// File: rtl/neo_frame_arbiter.sv
// Round-robin owner of one NeoPixel driver shared by NUM_REQ producers; ownership lasts
// from grant until the owner's send is accepted and the driver is ready again.
module neo_frame_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic               clock,
  input  logic               reset,
  neo_frame_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StGrant, StSending} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic               win;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      rr_next;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [NUM_REQ-1:0] req_rot;
    int unsigned        idx;
    win     = 1'b0;
    win_idx = '0;
    req_rot = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      req_rot = bus.req >> idx;
      if (!win && req_rot[0]) begin
        win     = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt = 32'(owner_q) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    rr_next = IW'(nxt);
  end

  always_comb begin
    logic               own_ld, own_snd, own_req;
    logic [3*NUM_REQ-1:0] pix_all;
    logic [2*NUM_REQ-1:0] cidx_all;
    logic [8*NUM_REQ-1:0] lvl_all;
    int unsigned        own;

    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = 1'b0;

    bus.load_color        = 1'b0;
    bus.send_it           = 1'b0;
    bus.pixel_index       = '0;
    bus.color_index       = '0;
    bus.color_level       = '0;
    bus.gnt_ready_to_load = '0;
    bus.gnt_ready_to_send = '0;

    // gnt_q is one-hot on the owner while busy, so it doubles as the select mask.
    own      = 32'(owner_q);
    own_ld   = |(bus.req_load_color & gnt_q);
    own_snd  = |(bus.req_send_it & gnt_q);
    own_req  = |(bus.req & gnt_q);
    pix_all  = bus.req_pixel_index >> (3 * own);
    cidx_all = bus.req_color_index >> (2 * own);
    lvl_all  = bus.req_color_level >> (8 * own);

    unique case (state_q)
      StIdle: begin
        if (win) begin
          gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d    = win_idx;
          hold_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        bus.send_it           = own_snd & bus.ready_to_send;
        bus.load_color        = own_ld & bus.ready_to_load & ~own_snd;
        bus.pixel_index       = pix_all[2:0];
        bus.color_index       = cidx_all[1:0];
        bus.color_level       = lvl_all[7:0];
        bus.gnt_ready_to_load = gnt_q & {NUM_REQ{bus.ready_to_load}};
        bus.gnt_ready_to_send = gnt_q & {NUM_REQ{bus.ready_to_send}};
        if (own_snd && bus.ready_to_send) begin
          state_d = StSending;
        end else if (!own_req) begin
          gnt_d    = '0;
          rr_ptr_d = rr_next;
          state_d  = StIdle;
        end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          timeout_err_d = 1'b1;
          gnt_d         = '0;
          rr_ptr_d      = rr_next;
          state_d       = StIdle;
        end else if (hold_cnt_q != {HW{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StSending: begin
        if (bus.ready_to_load || bus.ready_to_send) begin
          gnt_d    = '0;
          rr_ptr_d = rr_next;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      gnt_q         <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner_id    = owner_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_neo_frame_arbiter.sv
// Directed bench for neo_frame_arbiter: two producers, MAX_HOLD=8, expectations worked by hand.
module tb_neo_frame_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  neo_frame_arbiter_if #(.NUM_REQ(2)) bus ();

  neo_frame_arbiter #(
    .NUM_REQ (2),
    .MAX_HOLD(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] oh;
    logic [1:0] oh_next;
    int         who;
    int         other;

    bus.req             = '0;
    bus.req_load_color  = '0;
    bus.req_send_it     = '0;
    bus.req_pixel_index = '0;
    bus.req_color_index = '0;
    bus.req_color_level = '0;
    bus.ready_to_load   = 1'b0;
    bus.ready_to_send   = 1'b0;

    // Reset state
    @(posedge clock); #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_owner", 32'(bus.owner_id), 0);
    check("rst_timeout", 32'(bus.timeout_err), 0);
    check("rst_load", 32'(bus.load_color), 0);
    check("rst_send", 32'(bus.send_it), 0);
    check("rst_pixel", 32'(bus.pixel_index), 0);
    check("rst_rr", 32'(dut.rr_ptr_q), 0);

    // 1: single producer loads 5 pixels then sends
    @(negedge clock);
    reset   = 1'b0;
    bus.req = 2'b01;
    @(posedge clock); #1;
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_owner", 32'(bus.owner_id), 0);
    check("t1_busy", 32'(bus.busy), 1);
    for (int p = 0; p < 5; p++) begin
      @(negedge clock);
      bus.req_load_color  = 2'b01;
      bus.req_pixel_index = {3'd0, 3'(p)};
      bus.req_color_level = {8'h00, 8'(8'h40 + p)};
      bus.ready_to_load   = 1'b1;
      #1;
      check("t1_load", 32'(bus.load_color), 1);
      check("t1_pixel", 32'(bus.pixel_index), 32'(p));
      check("t1_level", 32'(bus.color_level), 32'(8'h40 + p));
      check("t1_rdy_load", 32'(bus.gnt_ready_to_load), 32'h1);
    end
    @(negedge clock);
    bus.req_load_color = 2'b00;
    bus.req_send_it    = 2'b01;
    bus.ready_to_load  = 1'b0;
    bus.ready_to_send  = 1'b1;
    #1;
    check("t1_send", 32'(bus.send_it), 1);
    check("t1_rdy_send", 32'(bus.gnt_ready_to_send), 32'h1);
    @(posedge clock); #1;
    check("t1_sending_busy", 32'(bus.busy), 1);
    check("t1_sending_gnt", 32'(bus.gnt), 32'h1);
    check("t1_sending_send", 32'(bus.send_it), 0);
    check("t1_sending_pixel", 32'(bus.pixel_index), 0);
    @(negedge clock);
    bus.req           = 2'b00;
    bus.req_send_it   = 2'b00;
    bus.ready_to_send = 1'b0;
    bus.ready_to_load = 1'b1;
    #1;
    check("t1_sending_rdy_load", 32'(bus.gnt_ready_to_load), 0);
    @(posedge clock); #1;
    check("t1_release_gnt", 32'(bus.gnt), 0);
    check("t1_release_busy", 32'(bus.busy), 0);
    check("t1_release_rr", 32'(dut.rr_ptr_q), 1);
    @(negedge clock);
    bus.ready_to_load = 1'b0;

    // 2: both request continuously, alternating grants
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    bus.req = 2'b11;
    @(posedge clock); #1;
    check("t2_first_gnt", 32'(bus.gnt), 32'h1);
    for (int r = 0; r < 4; r++) begin
      who     = r % 2;
      other   = (who + 1) % 2;
      oh      = 2'b01 << who;
      oh_next = 2'b01 << other;
      @(negedge clock);
      bus.req_load_color = oh;
      bus.ready_to_load  = 1'b1;
      #1;
      check("t2_load", 32'(bus.load_color), 1);
      check("t2_rdy_load", 32'(bus.gnt_ready_to_load), 32'(oh));
      @(negedge clock);
      bus.req_load_color = 2'b00;
      bus.req_send_it    = oh;
      bus.ready_to_load  = 1'b0;
      bus.ready_to_send  = 1'b1;
      #1;
      check("t2_send", 32'(bus.send_it), 1);
      @(negedge clock);
      bus.req_send_it   = 2'b00;
      bus.ready_to_send = 1'b0;
      bus.ready_to_load = 1'b1;
      #1;
      check("t2_sending_gnt", 32'(bus.gnt), 32'(oh));
      @(negedge clock);
      bus.ready_to_load = 1'b0;
      #1;
      check("t2_release_gnt", 32'(bus.gnt), 0);
      check("t2_release_rr", 32'(dut.rr_ptr_q), 32'(other));
      @(posedge clock); #1;
      check("t2_next_gnt", 32'(bus.gnt), 32'(oh_next));
    end

    // 3: simultaneous load and send from owner 0; send wins
    @(negedge clock);
    bus.req_load_color = 2'b01;
    bus.req_send_it    = 2'b01;
    bus.ready_to_load  = 1'b1;
    bus.ready_to_send  = 1'b1;
    #1;
    check("t3_send", 32'(bus.send_it), 1);
    check("t3_load", 32'(bus.load_color), 0);
    @(posedge clock); #1;
    check("t3_sending_busy", 32'(bus.busy), 1);
    check("t3_sending_gnt", 32'(bus.gnt), 32'h1);
    check("t3_sending_send", 32'(bus.send_it), 0);
    check("t3_sending_rdy_send", 32'(bus.gnt_ready_to_send), 0);
    @(negedge clock);
    bus.req_load_color = 2'b00;
    bus.req_send_it    = 2'b00;
    bus.req            = 2'b00;
    @(posedge clock); #1;
    check("t3_release_busy", 32'(bus.busy), 0);
    check("t3_release_rr", 32'(dut.rr_ptr_q), 1);

    // 4: producer 1 holds without sending; revoked after 8 cycles
    @(negedge clock);
    bus.ready_to_load = 1'b0;
    bus.ready_to_send = 1'b0;
    bus.req           = 2'b11;
    @(posedge clock); #1;
    check("t4_gnt", 32'(bus.gnt), 32'h2);
    for (int c = 1; c < 8; c++) begin
      @(posedge clock); #1;
      check("t4_hold_timeout", 32'(bus.timeout_err), 0);
      check("t4_hold_gnt", 32'(bus.gnt), 32'h2);
    end
    @(posedge clock); #1;
    check("t4_timeout", 32'(bus.timeout_err), 1);
    check("t4_revoke_gnt", 32'(bus.gnt), 0);
    check("t4_revoke_rr", 32'(dut.rr_ptr_q), 0);
    @(posedge clock); #1;
    check("t4_pulse_end", 32'(bus.timeout_err), 0);
    check("t4_other_gnt", 32'(bus.gnt), 32'h1);

    // 5: non-owner strobes are ignored
    @(negedge clock);
    bus.req_load_color  = 2'b10;
    bus.req_send_it     = 2'b10;
    bus.req_pixel_index = {3'd7, 3'd0};
    bus.req_color_level = {8'hff, 8'h00};
    bus.ready_to_load   = 1'b1;
    bus.ready_to_send   = 1'b1;
    #1;
    check("t5_load", 32'(bus.load_color), 0);
    check("t5_send", 32'(bus.send_it), 0);
    check("t5_pixel", 32'(bus.pixel_index), 0);
    check("t5_level", 32'(bus.color_level), 0);
    check("t5_rdy_load", 32'(bus.gnt_ready_to_load), 32'h1);
    check("t5_rdy_send", 32'(bus.gnt_ready_to_send), 32'h1);

    // 6: asynchronous reset during an owner load
    @(negedge clock);
    bus.req_load_color  = 2'b01;
    bus.req_send_it     = 2'b00;
    bus.req_pixel_index = {3'd7, 3'd3};
    #1;
    check("t6_load_before", 32'(bus.load_color), 1);
    check("t6_pixel_before", 32'(bus.pixel_index), 3);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 0);
    check("t6_rst_load", 32'(bus.load_color), 0);
    check("t6_rst_pixel", 32'(bus.pixel_index), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_rr", 32'(dut.rr_ptr_q), 0);
    @(negedge clock);
    reset              = 1'b0;
    bus.req            = 2'b10;
    bus.req_load_color = 2'b00;
    bus.ready_to_load  = 1'b0;
    bus.ready_to_send  = 1'b0;
    @(posedge clock); #1;
    check("t6_regrant_gnt", 32'(bus.gnt), 32'h2);
    check("t6_regrant_owner", 32'(bus.owner_id), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
